// File: rtl/bus_hold_arbiter.sv
// ----------------------------------------------------------------------------
// bus_hold_arbiter
//
// Shares the 8088 local bus between the CPU and up to NREQ bus masters. The
// CPU is asked to float the bus through its HOLD/HLDA handshake. Once the CPU
// has let go (plus an optional turnaround), exactly one requester is granted,
// picked round-robin. Each grant is limited to MAX_TENURE cycles. After every
// grant the bus goes back to the CPU for at least CPU_GAP cycles, so a busy
// requester can never starve the processor.
//
// Parameters
//   NREQ        number of requesters (2..8)
//   MAX_TENURE  maximum number of GNT-high cycles per grant (>=2)
//   GUARD       turnaround cycles between HLDA seen high and GNT (0..7)
//   CPU_GAP     minimum HOLD-low cycles after HLDA is seen low (>=1)
//
// Ports
//   CLK        in   system clock, everything changes on posedge
//   RESET_N    in   asynchronous active-low reset
//   REQ        in   per-requester level request, held until the master is done
//   HLDA       in   hold acknowledge from the CPU
//   HOLD       out  hold request to the CPU
//   GNT        out  one-hot grant, at most one bit set
//   OWNER      out  index of the current or most recent winner
//   BUS_OWNED  out  high exactly when a GNT bit is high
//   PREEMPT    out  one-cycle pulse when a grant is cut off by the tenure limit
//   ERR        out  sticky flag, CPU dropped HLDA while a grant was active
//
// Every output is a flop. Reset clears them asynchronously, so a reset that
// arrives during a grant releases the bus at once.
// ----------------------------------------------------------------------------
module bus_hold_arbiter #(
    parameter int NREQ       = 4,
    parameter int MAX_TENURE = 64,
    parameter int GUARD      = 1,
    parameter int CPU_GAP    = 4
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [NREQ-1:0]         REQ,
    input  logic                    HLDA,
    output logic                    HOLD,
    output logic [NREQ-1:0]         GNT,
    output logic [$clog2(NREQ)-1:0] OWNER,
    output logic                    BUS_OWNED,
    output logic                    PREEMPT,
    output logic                    ERR
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int TEN_W = $clog2(MAX_TENURE + 1);
    localparam int GAP_W = $clog2(CPU_GAP + 1);

    // Terminal counts. Each counter starts at zero on the edge that enters its
    // state, so the state is left on the edge where the count equals N-1.
    localparam int                GUARD_LAST_I = (GUARD > 0) ? GUARD - 1 : 0;
    localparam logic [2:0]        GUARD_LAST   = 3'(GUARD_LAST_I);
    localparam logic [TEN_W-1:0]  TENURE_LAST  = TEN_W'(MAX_TENURE - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST     = GAP_W'(CPU_GAP - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST     = PTR_W'(NREQ - 1);
    localparam logic [NREQ-1:0]   GNT_ONE      = NREQ'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD_REQ,
        ST_GUARD,
        ST_GRANT,
        ST_RELEASE,
        ST_GAP
    } ArbState;

    ArbState           state;
    ArbState           stateNext;

    logic [PTR_W-1:0]  rrPtr;
    logic [2:0]        guardCnt;
    logic [TEN_W-1:0]  tenureCnt;
    logic [GAP_W-1:0]  gapCnt;

    logic              winnerFound;
    logic [PTR_W-1:0]  winnerIdx;
    logic [PTR_W-1:0]  candIdx;

    logic              grantNow;
    logic              preemptNow;
    logic              violationNow;
    logic              leaveGrant;

    logic              holdNext;
    logic [NREQ-1:0]   gntNext;
    logic [PTR_W-1:0]  ownerNext;
    logic              busOwnedNext;
    logic              preemptNext;
    logic              errNext;

    // Round-robin pick: walk upward from the pointer with wrap-around and take
    // the first requester that is asking right now. The result is only used
    // on the edge that actually issues a grant.
    always_comb begin
        winnerFound = 1'b0;
        winnerIdx   = '0;
        candIdx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            candIdx = PTR_W'((int'(rrPtr) + i) % NREQ);
            if (!winnerFound && REQ[candIdx]) begin
                winnerFound = 1'b1;
                winnerIdx   = candIdx;
            end
        end
    end

    // State register. The only job of this process is to move the FSM; the
    // counters and outputs have their own flops further down.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic. It also raises one-cycle event flags (grant issued,
    // tenure preemption, HLDA violation, grant ended) for the output logic.
    // Inside GRANT, a lost HLDA wins over everything else because the CPU may
    // already be driving the bus. A requester that lets go on the very edge
    // the tenure runs out counts as a normal release, not a preemption.
    always_comb begin
        stateNext    = state;
        grantNow     = 1'b0;
        preemptNow   = 1'b0;
        violationNow = 1'b0;
        leaveGrant   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|REQ) begin
                    stateNext = ST_HOLD_REQ;
                end
            end
            ST_HOLD_REQ: begin
                if (HLDA) begin
                    if (GUARD == 0) begin
                        if (winnerFound) begin
                            stateNext = ST_GRANT;
                            grantNow  = 1'b1;
                        end else begin
                            stateNext = ST_RELEASE;
                        end
                    end else begin
                        stateNext = ST_GUARD;
                    end
                end
            end
            ST_GUARD: begin
                if (!HLDA) begin
                    stateNext = ST_GAP;
                end else if (guardCnt == GUARD_LAST) begin
                    if (winnerFound) begin
                        stateNext = ST_GRANT;
                        grantNow  = 1'b1;
                    end else begin
                        stateNext = ST_RELEASE;
                    end
                end
            end
            ST_GRANT: begin
                if (!HLDA) begin
                    stateNext    = ST_GAP;
                    violationNow = 1'b1;
                    leaveGrant   = 1'b1;
                end else if (!REQ[OWNER]) begin
                    stateNext  = ST_RELEASE;
                    leaveGrant = 1'b1;
                end else if (tenureCnt == TENURE_LAST) begin
                    stateNext  = ST_RELEASE;
                    preemptNow = 1'b1;
                    leaveGrant = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!HLDA) begin
                    stateNext = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gapCnt == GAP_LAST) begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Output logic. It computes the value every registered output takes after
    // the coming edge. HOLD follows the destination state. GNT is loaded only
    // when a grant is issued and is kept while the FSM stays in GRANT.
    always_comb begin
        holdNext     = (stateNext == ST_HOLD_REQ) ||
                       (stateNext == ST_GUARD)    ||
                       (stateNext == ST_GRANT);
        gntNext      = '0;
        ownerNext    = OWNER;
        busOwnedNext = (stateNext == ST_GRANT);
        preemptNext  = preemptNow;
        errNext      = ERR | violationNow;
        if (grantNow) begin
            gntNext   = GNT_ONE << winnerIdx;
            ownerNext = winnerIdx;
        end else if (stateNext == ST_GRANT) begin
            gntNext = GNT;
        end
    end

    // Cycle counters for turnaround, tenure and CPU gap. Each one runs only
    // while its state is held, so it is cleared on entry by construction.
    // The round-robin pointer moves past the winner whenever a grant ends,
    // whatever the reason, which keeps the rotation fair.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            guardCnt  <= '0;
            tenureCnt <= '0;
            gapCnt    <= '0;
            rrPtr     <= '0;
        end else begin
            guardCnt  <= (state == ST_GUARD && stateNext == ST_GUARD)
                         ? guardCnt + 3'd1 : 3'd0;
            tenureCnt <= (state == ST_GRANT && stateNext == ST_GRANT)
                         ? tenureCnt + 1'b1 : '0;
            gapCnt    <= (state == ST_GAP && stateNext == ST_GAP)
                         ? gapCnt + 1'b1 : '0;
            if (leaveGrant) begin
                rrPtr <= (OWNER == PTR_LAST) ? '0 : OWNER + 1'b1;
            end
        end
    end

    // Output flops. The asynchronous clear drops HOLD and GNT as soon as
    // RESET_N falls, without waiting for a clock.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            HOLD      <= 1'b0;
            GNT       <= '0;
            OWNER     <= '0;
            BUS_OWNED <= 1'b0;
            PREEMPT   <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            HOLD      <= holdNext;
            GNT       <= gntNext;
            OWNER     <= ownerNext;
            BUS_OWNED <= busOwnedNext;
            PREEMPT   <= preemptNext;
            ERR       <= errNext;
        end
    end

    // Structural guarantees: the grant is never shared between two masters,
    // and BUS_OWNED always agrees with the grant vector.
    assert property (@(posedge CLK) disable iff (!RESET_N) $onehot0(GNT));
    assert property (@(posedge CLK) disable iff (!RESET_N) BUS_OWNED == (|GNT));

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_hold_arbiter
//
// Self-checking bench for bus_hold_arbiter with NREQ=4, MAX_TENURE=64,
// GUARD=1, CPU_GAP=4. The bench also plays the CPU and drives HLDA
// explicitly in every cycle. Each stimulus record holds the inputs for one
// clock and the outputs expected after that edge. The expectation is queued
// when the inputs are driven and popped when the outputs are sampled on the
// following falling edge.
// ----------------------------------------------------------------------------
module tb_bus_hold_arbiter;

    localparam int NREQ = 4;

    logic            CLK;
    logic            RESET_N;
    logic [NREQ-1:0] REQ;
    logic            HLDA;
    logic            HOLD;
    logic [NREQ-1:0] GNT;
    logic [1:0]      OWNER;
    logic            BUS_OWNED;
    logic            PREEMPT;
    logic            ERR;

    typedef struct {
        logic [NREQ-1:0] req;
        logic            hlda;
        logic            hold;
        logic [NREQ-1:0] gnt;
        logic [1:0]      owner;
        logic            preempt;
        logic            err;
    } VecRec;

    VecRec vecTable[$];
    VecRec expQ[$];

    int         checks = 0;
    int         errors = 0;
    int         stepNo = 0;
    logic [1:0] lastOwner = 2'd0;
    logic       expErr = 1'b0;

    bus_hold_arbiter #(
        .NREQ      (4),
        .MAX_TENURE(64),
        .GUARD     (1),
        .CPU_GAP   (4)
    ) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .REQ      (REQ),
        .HLDA     (HLDA),
        .HOLD     (HOLD),
        .GNT      (GNT),
        .OWNER    (OWNER),
        .BUS_OWNED(BUS_OWNED),
        .PREEMPT  (PREEMPT),
        .ERR      (ERR)
    );

    // 10 ns clock; inputs change and outputs are sampled on the falling edge.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Safety net so that a stuck run still terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, required normal finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compares one field and keeps the check and error counts.
    task automatic compareField(input string name, input logic [7:0] actual,
                                input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s step %0d: got %0h, required %0h",
                     name, stepNo, actual, expected);
        end
    endtask

    // Adds one record to the vector table.
    task automatic addVec(input logic [3:0] req, input logic hlda,
                          input logic hold, input logic [3:0] gnt,
                          input logic [1:0] owner, input logic preempt,
                          input logic err);
        VecRec r;
        r.req = req; r.hlda = hlda; r.hold = hold; r.gnt = gnt;
        r.owner = owner; r.preempt = preempt; r.err = err;
        vecTable.push_back(r);
    endtask

    // Drives one cycle of inputs, queues its expectation, then waits until
    // the falling edge after the sampling edge.
    task automatic applyStimulus(input VecRec v);
        REQ  = v.req;
        HLDA = v.hlda;
        expQ.push_back(v);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Pops the oldest expectation and compares all outputs against it.
    task automatic checkOutput();
        VecRec e;
        stepNo++;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard step %0d: got empty queue, required entry",
                     stepNo);
            return;
        end
        e = expQ.pop_front();
        compareField("HOLD",      {7'b0, HOLD},      {7'b0, e.hold});
        compareField("GNT",       {4'b0, GNT},       {4'b0, e.gnt});
        compareField("OWNER",     {6'b0, OWNER},     {6'b0, e.owner});
        compareField("BUS_OWNED", {7'b0, BUS_OWNED}, {7'b0, (e.gnt != 4'b0)});
        compareField("PREEMPT",   {7'b0, PREEMPT},   {7'b0, e.preempt});
        compareField("ERR",       {7'b0, ERR},       {7'b0, e.err});
    endtask

    // One cycle from a hand-written sequence, with ERR taken from the
    // bench's own expectation.
    task automatic runVec(input logic [3:0] req, input logic hlda,
                          input logic hold, input logic [3:0] gnt,
                          input logic [1:0] owner, input logic preempt);
        VecRec r;
        r.req = req; r.hlda = hlda; r.hold = hold; r.gnt = gnt;
        r.owner = owner; r.preempt = preempt; r.err = expErr;
        applyStimulus(r);
        checkOutput();
    endtask

    // A full grant cycle, starting from IDLE, for a requester that never lets
    // go. The grant runs to the 64-cycle tenure limit, and the CPU gap follows.
    // With dropAtExpiry set, the request falls on the expiry edge itself, which
    // must count as a normal release with no preemption pulse.
    task automatic grantCycle(input logic [3:0] req, input logic [1:0] expOwner,
                              input logic dropAtExpiry);
        logic [3:0] oneHot;
        logic [3:0] reqAfter;
        oneHot   = 4'b0001 << expOwner;
        reqAfter = dropAtExpiry ? 4'b0000 : req;
        runVec(req, 1'b0, 1'b1, 4'b0000, lastOwner, 1'b0);
        runVec(req, 1'b1, 1'b1, 4'b0000, lastOwner, 1'b0);
        runVec(req, 1'b1, 1'b1, oneHot, expOwner, 1'b0);
        lastOwner = expOwner;
        for (int i = 1; i < 64; i++) begin
            runVec(req, 1'b1, 1'b1, oneHot, expOwner, 1'b0);
        end
        runVec(reqAfter, 1'b1, 1'b0, 4'b0000, expOwner, ~dropAtExpiry);
        runVec(reqAfter, 1'b1, 1'b0, 4'b0000, expOwner, 1'b0);
        runVec(reqAfter, 1'b0, 1'b0, 4'b0000, expOwner, 1'b0);
        for (int i = 0; i < 4; i++) begin
            runVec(reqAfter, 1'b0, 1'b0, 4'b0000, expOwner, 1'b0);
        end
    endtask

    initial begin
        // Vector table: request/release, CPU gap, wrap-around pick, HLDA
        // violation, request pulse with no grant, and a grant to requester 1.
        //     req      hlda  hold  gnt      own   pre   err
        addVec(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++)
            addVec(4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
        addVec(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            addVec(4'b0001, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0);
        addVec(4'b0001, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
        addVec(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            addVec(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
        addVec(4'b0100, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1);
        addVec(4'b0000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1);
        addVec(4'b0000, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1);
        addVec(4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
        addVec(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            addVec(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b1);
        addVec(4'b0010, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1);
        addVec(4'b0010, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1);
        addVec(4'b0010, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1);

        // Reset values, checked while reset is held and before any edge.
        RESET_N = 1'b0;
        REQ     = '0;
        HLDA    = 1'b0;
        #3;
        compareField("reset HOLD",    {7'b0, HOLD},      8'h00);
        compareField("reset GNT",     {4'b0, GNT},       8'h00);
        compareField("reset OWNER",   {6'b0, OWNER},     8'h00);
        compareField("reset BUSOWN",  {7'b0, BUS_OWNED}, 8'h00);
        compareField("reset PREEMPT", {7'b0, PREEMPT},   8'h00);
        compareField("reset ERR",     {7'b0, ERR},       8'h00);
        @(posedge CLK);
        @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;

        for (int i = 0; i < vecTable.size(); i++) begin
            applyStimulus(vecTable[i]);
            checkOutput();
        end

        // Reset while requester 1 holds the grant: everything must clear
        // without a clock edge, including the sticky ERR.
        #2;
        RESET_N = 1'b0;
        #1;
        compareField("midreset HOLD",  {7'b0, HOLD},      8'h00);
        compareField("midreset GNT",   {4'b0, GNT},       8'h00);
        compareField("midreset OWNER", {6'b0, OWNER},     8'h00);
        compareField("midreset BUSOWN",{7'b0, BUS_OWNED}, 8'h00);
        compareField("midreset ERR",   {7'b0, ERR},       8'h00);
        REQ  = '0;
        HLDA = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RESET_N   = 1'b1;
        lastOwner = 2'd0;
        expErr    = 1'b0;

        // All four requesters stay busy: the grants rotate 0,1,2,3,0, each
        // ends by preemption, and a CPU gap separates every pair of grants.
        grantCycle(4'b1111, 2'd0, 1'b0);
        grantCycle(4'b1111, 2'd1, 1'b0);
        grantCycle(4'b1111, 2'd2, 1'b0);
        grantCycle(4'b1111, 2'd3, 1'b0);
        grantCycle(4'b1111, 2'd0, 1'b0);

        // Only requester 2 is busy: it is preempted after 64 cycles and
        // granted again after the gap. On the second grant it lets go exactly
        // on the expiry edge.
        grantCycle(4'b0100, 2'd2, 1'b0);
        grantCycle(4'b0100, 2'd2, 1'b1);
        runVec(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
